// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter: requester ownership tags,
// default bus widths and the fixed read-return latency.
package vram_pkg;

  localparam int ADDR_W_DEF   = 14;
  localparam int DATA_W_DEF   = 8;
  localparam int READ_LATENCY = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/vram_arbiter_chk.sv
// Protocol checker for the VRAM arbiter: ack/rvalid exclusivity and
// requester stability while a request waits for its grant.
module vram_arbiter_chk #(
  parameter int ADDR_W = 14
) (
  input logic              clk,
  input logic              reset,
  input logic              vid_req,
  input logic [ADDR_W-1:0] vid_addr,
  input logic              vid_ack,
  input logic              cpu_req,
  input logic              cpu_we,
  input logic [ADDR_W-1:0] cpu_addr,
  input logic              cpu_ack,
  input logic              vid_rvalid,
  input logic              cpu_rvalid
);

  a_one_ack: assert property (@(posedge clk) !(vid_ack && cpu_ack));

  a_one_rvalid: assert property (@(posedge clk) !(vid_rvalid && cpu_rvalid));

  // A pending request may be withdrawn, but never retargeted before its grant
  a_cpu_hold: assert property (@(posedge clk) disable iff (reset)
    (cpu_req && !cpu_ack) |=> (!cpu_req || ($stable(cpu_addr) && $stable(cpu_we))));

  a_vid_hold: assert property (@(posedge clk) disable iff (reset)
    (vid_req && !vid_ack) |=> (!vid_req || $stable(vid_addr)));

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester arbiter for a single-port synchronous VRAM: video scanout has
// priority except during blanking or once the CPU starvation guard expires.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 15
) (
  input  logic              I_clock,
  input  logic              I_reset,
  input  logic              I_vid_blank,
  input  logic              I_vid_req,
  input  logic [ADDR_W-1:0] I_vid_addr,
  output logic              O_vid_ack,
  output logic              O_vid_rvalid,
  output logic [DATA_W-1:0] O_vid_rdata,
  input  logic              I_cpu_req,
  input  logic              I_cpu_we,
  input  logic [ADDR_W-1:0] I_cpu_addr,
  input  logic [DATA_W-1:0] I_cpu_wdata,
  output logic              O_cpu_ack,
  output logic              O_cpu_rvalid,
  output logic [DATA_W-1:0] O_cpu_rdata,
  output logic              O_mem_en,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [DATA_W-1:0] O_mem_wdata,
  input  logic [DATA_W-1:0] I_mem_rdata
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]                  starve_cnt_r;
  logic                        cpu_force_s;
  logic                        vid_grant_s;
  logic                        cpu_grant_s;
  owner_t                      issue_s;
  owner_t [READ_LATENCY-1:0]   tag_r;
  logic                        mem_en_r;
  logic                        mem_we_r;
  logic [ADDR_W-1:0]           mem_addr_r;
  logic [DATA_W-1:0]           mem_wdata_r;

  // Grant selection for the current cycle from the live requests
  always_comb begin
    cpu_force_s = I_vid_blank || (starve_cnt_r == STARVE_LIM);
    vid_grant_s = 1'b0;
    cpu_grant_s = 1'b0;
    if (I_reset) begin
      vid_grant_s = 1'b0;
      cpu_grant_s = 1'b0;
    end else if (I_cpu_req && (!I_vid_req || cpu_force_s)) begin
      cpu_grant_s = 1'b1;
    end else if (I_vid_req) begin
      vid_grant_s = 1'b1;
    end else begin
      vid_grant_s = 1'b0;
      cpu_grant_s = 1'b0;
    end
  end

  // Owner of the read being issued this cycle; writes return nothing
  always_comb begin
    issue_s = OWN_NONE;
    if (cpu_grant_s && !I_cpu_we) begin
      issue_s = OWN_CPU;
    end else if (vid_grant_s) begin
      issue_s = OWN_VID;
    end else begin
      issue_s = OWN_NONE;
    end
  end

  // RAM command register; wdata only moves on a CPU write
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (cpu_grant_s) begin
      mem_en_r   <= 1'b1;
      mem_we_r   <= I_cpu_we;
      mem_addr_r <= I_cpu_addr;
      if (I_cpu_we) begin
        mem_wdata_r <= I_cpu_wdata;
      end
    end else if (vid_grant_s) begin
      mem_en_r   <= 1'b1;
      mem_we_r   <= 1'b0;
      mem_addr_r <= I_vid_addr;
    end else begin
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
    end
  end

  // Read-return owner pipeline; reset drops anything in flight
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      tag_r <= {READ_LATENCY{OWN_NONE}};
    end else begin
      tag_r[0] <= issue_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Consecutive denied-CPU-cycle counter, saturating at the force threshold
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      starve_cnt_r <= 8'd0;
    end else if (!I_cpu_req || cpu_grant_s) begin
      starve_cnt_r <= 8'd0;
    end else if (starve_cnt_r != STARVE_LIM) begin
      starve_cnt_r <= starve_cnt_r + 8'd1;
    end
  end

  assign O_vid_ack    = vid_grant_s;
  assign O_cpu_ack    = cpu_grant_s;
  assign O_mem_en     = mem_en_r;
  assign O_mem_we     = mem_we_r;
  assign O_mem_addr   = mem_addr_r;
  assign O_mem_wdata  = mem_wdata_r;
  assign O_vid_rvalid = (tag_r[READ_LATENCY-1] == OWN_VID);
  assign O_cpu_rvalid = (tag_r[READ_LATENCY-1] == OWN_CPU);
  assign O_vid_rdata  = I_mem_rdata;
  assign O_cpu_rdata  = I_mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus a randomized
// run, all scored against a due-time return queue and a shadow memory.
module tb_vram_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int SM = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vid_blank = 1'b0, vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] vid_addr = 14'h0000, cpu_addr = 14'h0000;
  logic [DW-1:0] cpu_wdata = 8'h00, mem_rdata;
  logic          vid_ack, vid_rvalid, cpu_ack, cpu_rvalid, mem_en, mem_we;
  logic [DW-1:0] vid_rdata, cpu_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .I_clock(clk), .I_reset(rst), .I_vid_blank(vid_blank),
    .I_vid_req(vid_req), .I_vid_addr(vid_addr), .O_vid_ack(vid_ack),
    .O_vid_rvalid(vid_rvalid), .O_vid_rdata(vid_rdata),
    .I_cpu_req(cpu_req), .I_cpu_we(cpu_we), .I_cpu_addr(cpu_addr),
    .I_cpu_wdata(cpu_wdata), .O_cpu_ack(cpu_ack), .O_cpu_rvalid(cpu_rvalid),
    .O_cpu_rdata(cpu_rdata), .O_mem_en(mem_en), .O_mem_we(mem_we),
    .O_mem_addr(mem_addr), .O_mem_wdata(mem_wdata), .I_mem_rdata(mem_rdata)
  );

  vram_arbiter_chk #(.ADDR_W(AW)) chk (
    .clk(clk), .reset(rst), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_ack(vid_ack), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .vid_rvalid(vid_rvalid),
    .cpu_rvalid(cpu_rvalid)
  );

  // Synchronous RAM; unwritten locations read back as addr[7:0]
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit            ram_wr [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
      end
    end
  end

  // Reference model: due-cycle return queue, shadow memory, denied streak
  typedef struct { int due; int own; logic [DW-1:0] data; } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] sh [0:(1<<AW)-1];
  bit            sh_wr [0:(1<<AW)-1];
  int            cyc = 0, starve = 0, checks = 0, fails = 0;
  logic          e_vid_ack, e_cpu_ack, e_vid_rv, e_cpu_rv;
  logic [DW-1:0] e_rdata;
  logic          e_en = 1'b0, e_we = 1'b0, n_en = 1'b0, n_we = 1'b0;
  logic [AW-1:0] e_addr = 14'h0000, n_addr = 14'h0000;
  logic [DW-1:0] e_wdata = 8'h00, n_wdata = 8'h00;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return sh_wr[a] ? sh[a] : a[7:0];
  endfunction

  task automatic predict();
    bit force_cpu;
    force_cpu = vid_blank || (starve == SM);
    e_cpu_ack = !rst && cpu_req && (!vid_req || force_cpu);
    e_vid_ack = !rst && vid_req && !e_cpu_ack;
    e_vid_rv = 1'b0;
    e_cpu_rv = 1'b0;
    e_rdata  = 8'h00;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_vid_rv = (rq[0].own == 1);
      e_cpu_rv = (rq[0].own == 2);
      e_rdata  = rq[0].data;
    end
  endtask

  task automatic step();
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    if (rst) begin
      starve = 0; rq.delete();
      n_en = 1'b0; n_we = 1'b0; n_addr = 14'h0000; n_wdata = 8'h00;
    end else begin
      if (e_cpu_ack) begin
        n_en = 1'b1; n_we = cpu_we; n_addr = cpu_addr;
        if (cpu_we) begin
          n_wdata = cpu_wdata; sh[cpu_addr] = cpu_wdata; sh_wr[cpu_addr] = 1'b1;
        end else begin
          rq.push_back('{cyc + 2, 2, ref_rd(cpu_addr)});
        end
      end else if (e_vid_ack) begin
        n_en = 1'b1; n_we = 1'b0; n_addr = vid_addr;
        rq.push_back('{cyc + 2, 1, ref_rd(vid_addr)});
      end else begin
        n_en = 1'b0; n_we = 1'b0;
      end
      if (!cpu_req || e_cpu_ack) starve = 0;
      else if (starve < SM) starve++;
    end
    @(posedge clk);
    cyc++;
    e_en = n_en; e_we = n_we; e_addr = n_addr; e_wdata = n_wdata;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    vid_blank = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 14'h0055; cpu_wdata = 8'h5A; vid_addr = 14'h0066;
    for (int i = 0; i < 2; i++) begin
      #1; predict();
      checks++;
      if (vid_ack !== 1'b0 || cpu_ack !== 1'b0) begin
        fails++; $display("FAIL reset_ack i=%0d got vid=%b cpu=%b want 0 0", i, vid_ack, cpu_ack);
      end
      step();
    end
    rst = 1'b0; idle_inputs();
    #1; predict();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, vid_rvalid, cpu_rvalid} !== 26'd0) begin
      fails++; $display("FAIL reset_state got en=%b we=%b addr=%h wd=%h rv=%b%b want all 0",
                        mem_en, mem_we, mem_addr, mem_wdata, vid_rvalid, cpu_rvalid);
    end
    step();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      #1; predict();
      checks++;
      if ({mem_en, vid_ack, cpu_ack, vid_rvalid, cpu_rvalid} !== 5'd0) begin
        fails++; $display("FAIL idle i=%0d got en/acks/rvalids=%b want 00000", i,
                          {mem_en, vid_ack, cpu_ack, vid_rvalid, cpu_rvalid});
      end
      step();
    end
  endtask

  task automatic test_video_stream();
    logic exp_rv, exp_en;
    for (int i = 0; i < 11; i++) begin
      vid_req = (i < 8); vid_addr = 14'h0100 + 14'(i);
      #1; predict();
      exp_rv = (i >= 2 && i < 10);
      exp_en = (i >= 1 && i < 9);
      checks++;
      if (vid_ack !== 1'(i < 8) || cpu_ack !== 1'b0) begin
        fails++; $display("FAIL vid_stream_ack i=%0d got vid=%b cpu=%b want %b 0", i, vid_ack, cpu_ack, 1'(i < 8));
      end
      checks++;
      if (vid_rvalid !== exp_rv || cpu_rvalid !== 1'b0) begin
        fails++; $display("FAIL vid_stream_rvalid i=%0d got vid=%b cpu=%b want %b 0", i, vid_rvalid, cpu_rvalid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (vid_rdata !== 8'(i - 2)) begin
          fails++; $display("FAIL vid_stream_rdata i=%0d got %h want %h", i, vid_rdata, 8'(i - 2));
        end
      end
      checks++;
      if (mem_en !== exp_en || (exp_en && (mem_we !== 1'b0 || mem_addr !== 14'h0100 + 14'(i - 1)))) begin
        fails++; $display("FAIL vid_stream_cmd i=%0d got en=%b we=%b addr=%h want en=%b", i, mem_en, mem_we, mem_addr, exp_en);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    logic exp_cpu;
    vid_blank = 1'b0; vid_req = 1'b1; vid_addr = 14'h0300;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
    for (int i = 0; i < 36; i++) begin
      if (i >= 33) begin vid_req = 1'b0; cpu_req = 1'b0; end
      #1; predict();
      exp_cpu = (i == 15 || i == 31);
      if (i < 33) begin
        checks++;
        if (cpu_ack !== exp_cpu || vid_ack !== !exp_cpu) begin
          fails++; $display("FAIL contention_ack i=%0d got cpu=%b vid=%b want %b %b", i, cpu_ack, vid_ack, exp_cpu, !exp_cpu);
        end
      end
      checks++;
      if (vid_rvalid !== e_vid_rv || cpu_rvalid !== e_cpu_rv ||
          (e_vid_rv && vid_rdata !== e_rdata) || (e_cpu_rv && cpu_rdata !== e_rdata)) begin
        fails++; $display("FAIL contention_ret i=%0d got rv=%b%b vd=%h cd=%h want rv=%b%b d=%h",
                          i, vid_rvalid, cpu_rvalid, vid_rdata, cpu_rdata, e_vid_rv, e_cpu_rv, e_rdata);
      end
      step();
      if (e_vid_ack) vid_addr = vid_addr + 14'd1;
      if (e_cpu_ack) cpu_addr = cpu_addr + 14'd1;
    end
  endtask

  task automatic test_rvalid_order();
    for (int i = 0; i < 5; i++) begin
      vid_req = (i == 0); vid_addr = 14'h0010;
      cpu_req = (i <= 1); cpu_we = 1'b0; cpu_addr = 14'h0020;
      #1; predict();
      checks++;
      if (vid_ack !== 1'(i == 0) || cpu_ack !== 1'(i == 1)) begin
        fails++; $display("FAIL order_ack i=%0d got vid=%b cpu=%b", i, vid_ack, cpu_ack);
      end
      checks++;
      if (vid_rvalid !== 1'(i == 2) || cpu_rvalid !== 1'(i == 3)) begin
        fails++; $display("FAIL order_rvalid i=%0d got vid=%b cpu=%b want %b %b", i, vid_rvalid, cpu_rvalid, 1'(i == 2), 1'(i == 3));
      end
      if (i == 2 || i == 3) begin
        checks++;
        if ((i == 2 && vid_rdata !== 8'h10) || (i == 3 && cpu_rdata !== 8'h20)) begin
          fails++; $display("FAIL order_rdata i=%0d got vid=%h cpu=%h want 10/20", i, vid_rdata, cpu_rdata);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_blanking();
    vid_blank = 1'b1; vid_addr = 14'h0400; cpu_addr = 14'h3F00; cpu_wdata = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      vid_req = (i <= 2); cpu_req = (i <= 1); cpu_we = (i == 0);
      #1; predict();
      checks++;
      if (cpu_ack !== 1'(i <= 1) || vid_ack !== 1'(i == 2)) begin
        fails++; $display("FAIL blank_ack i=%0d got cpu=%b vid=%b", i, cpu_ack, vid_ack);
      end
      checks++;
      if (cpu_rvalid !== 1'(i == 3) || vid_rvalid !== 1'(i == 4)) begin
        fails++; $display("FAIL blank_rvalid i=%0d got cpu=%b vid=%b", i, cpu_rvalid, vid_rvalid);
      end
      if (i == 3) begin
        checks++;
        if (cpu_rdata !== 8'hA5) begin
          fails++; $display("FAIL blank_wr_rd got %h want a5", cpu_rdata);
        end
      end
      if (i == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 14'h3F00 || mem_wdata !== 8'hA5) begin
          fails++; $display("FAIL blank_wcmd got en=%b we=%b addr=%h wd=%h want 1 1 3f00 a5", mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    vid_addr = 14'h0500; cpu_we = 1'b0; cpu_addr = 14'h0600;
    for (int i = 0; i < 30; i++) begin
      rst = (i == 10);
      vid_req = (i != 10) && (i < 28);
      cpu_req = (i != 10) && (i <= 26);
      #1; predict();
      checks++;
      if (cpu_ack !== 1'(i == 26) || vid_ack !== e_vid_ack) begin
        fails++; $display("FAIL rmid_ack i=%0d got cpu=%b vid=%b want %b %b", i, cpu_ack, vid_ack, 1'(i == 26), e_vid_ack);
      end
      checks++;
      if (vid_rvalid !== e_vid_rv || cpu_rvalid !== e_cpu_rv) begin
        fails++; $display("FAIL rmid_rvalid i=%0d got %b%b want %b%b", i, vid_rvalid, cpu_rvalid, e_vid_rv, e_cpu_rv);
      end
      if (i == 11) begin
        checks++;
        if (mem_en !== 1'b0 || vid_rvalid !== 1'b0) begin
          fails++; $display("FAIL rmid_flush got en=%b vid_rvalid=%b want 0 0", mem_en, vid_rvalid);
        end
      end
      step();
      if (e_vid_ack) vid_addr = vid_addr + 14'd1;
    end
    rst = 1'b0; idle_inputs();
  endtask

  task automatic test_random();
    bit vid_hold = 1'b0, cpu_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      vid_blank = ($urandom_range(0, 7) == 0);
      if (!vid_hold) begin
        vid_req  = ($urandom_range(0, 3) != 0);
        vid_addr = 14'h3F00 + 14'($urandom_range(0, 15));
      end
      if (!cpu_hold) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 14'h3F00 + 14'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end
      #1; predict();
      checks++;
      if (vid_ack !== e_vid_ack || cpu_ack !== e_cpu_ack) begin
        fails++; $display("FAIL rnd_ack cyc=%0d got vid=%b cpu=%b want %b %b", cyc, vid_ack, cpu_ack, e_vid_ack, e_cpu_ack);
      end
      checks++;
      if (vid_rvalid !== e_vid_rv || cpu_rvalid !== e_cpu_rv ||
          (e_vid_rv && vid_rdata !== e_rdata) || (e_cpu_rv && cpu_rdata !== e_rdata)) begin
        fails++; $display("FAIL rnd_ret cyc=%0d got rv=%b%b vd=%h cd=%h want rv=%b%b d=%h",
                          cyc, vid_rvalid, cpu_rvalid, vid_rdata, cpu_rdata, e_vid_rv, e_cpu_rv, e_rdata);
      end
      checks++;
      if (mem_en !== e_en || mem_we !== e_we || (e_en && mem_addr !== e_addr) ||
          (e_en && e_we && mem_wdata !== e_wdata)) begin
        fails++; $display("FAIL rnd_cmd cyc=%0d got en=%b we=%b a=%h wd=%h want en=%b we=%b a=%h wd=%h",
                          cyc, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      end
      vid_hold = vid_req && !e_vid_ack;
      cpu_hold = cpu_req && !e_cpu_ack;
      step();
    end
    rst = 1'b0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_video_stream();
    test_contention();
    test_rvalid_order();
    test_blanking();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
